ether_tx_mux: RTL and testbench
===============================

Name: ether_tx_mux

Overview:
- Multi-channel successor to the single-channel serializer/ether_IF pair.
- Accepts CHANNEL_NUM independent AXI-Stream sources and buffers each in its own FIFO.
- Round-robin arbitrates between channels and emits Ethernet-MAC-ready frames on one 64-bit TX AXIS. Each frame gets a header word, and frames are split at a configurable maximum payload length.
- Sits between the per-channel front ends and the 10G MAC TX interface.

Parameters:
- CHANNEL_NUM, 4: number of input channels (1..16).
- TDATA_WIDTH, 64: data width of every input and of the output.
- FIFO_DEPTH, 16: words per channel FIFO; must be a power of 2 and ≥ MAX_PAYLOAD_WORDS.
- MAX_PAYLOAD_WORDS, 8: maximum payload words per output frame, excluding the header.

Ports:
- TX_ACLK  in  1  sole clock.
- TX_ARESETN  in  1  asynchronous active-low reset.
- S_AXIS_TDATA  in  CHANNEL_NUM*TDATA_WIDTH  channel c at bits [c*64 +: 64].
- S_AXIS_TVALID  in  CHANNEL_NUM  per-channel valid.
- S_AXIS_TLAST  in  CHANNEL_NUM  per-channel end of packet.
- S_AXIS_TREADY  out  CHANNEL_NUM  per-channel ready; equals FIFO not full.
- TX_M_AXIS_TDATA  out  TDATA_WIDTH  frame word.
- TX_M_AXIS_TKEEP  out  8  byte enables.
- TX_M_AXIS_TVALID  out  1  output valid.
- TX_M_AXIS_TLAST  out  1  last word of frame.
- TX_M_AXIS_TUSER  out  1  MAC abort flag; always 0.
- TX_M_AXIS_TREADY  in  1  MAC ready.
- GRANT_CH  out  4  channel currently or last granted.
- SPLIT_CNT  out  16  count of frames closed by the length limit; saturating.

Behaviour:
- Reset:
  - Single clock TX_ACLK; TX_ARESETN is asynchronous, active-low.
  - During reset: all FIFOs empty, S_AXIS_TREADY = 0, all TX_M_AXIS outputs 0 except TKEEP = 8'hFF.
  - Also on reset: GRANT_CH = 0, SPLIT_CNT = 0, sequence counters = 0, round-robin pointer = CHANNEL_NUM-1 (so channel 0 wins first).
  - Reset mid-frame discards the frame; no TLAST is emitted.
- Input side:
  - A word (TDATA, TLAST) is written when TVALID & TREADY.
  - Per channel, the block keeps a word count and a complete-packet count (number of TLAST words held).
  - Simultaneous write and read of the same FIFO leaves the word count unchanged; the same rule applies to the packet count.
  - FIFO full → TREADY = 0 for that channel only.
- Eligibility: a channel is eligible when its packet count > 0 or its word count ≥ MAX_PAYLOAD_WORDS. This guarantees a frame never underruns mid-transfer.
- FSM states: IDLE, HEADER, PAYLOAD.
  - IDLE: search from pointer+1 upward, wrapping, for the first eligible channel. On a hit, latch it into GRANT_CH and go to HEADER next cycle. With none eligible, stay in IDLE with TVALID = 0.
  - HEADER: TVALID = 1, TLAST = 0. TDATA = {8'hAA, 4'h0, GRANT_CH, seq[ch][15:0], cont[ch], 31'h0}, where cont = 1 if the previous frame of this channel was split. Go to PAYLOAD on handshake.
  - PAYLOAD: TDATA = FIFO head word, TVALID held 1 continuously. A FIFO word is popped on each handshake, and the payload counter increments.
    - TLAST = head word's stored TLAST, OR payload counter == MAX_PAYLOAD_WORDS-1.
    - On the TLAST handshake: go to IDLE, set pointer = GRANT_CH, and increment seq[ch] (16-bit, 0xFFFF wraps to 0).
    - Set cont[ch] = 1 if the frame ended by the limit without a stored TLAST; otherwise set cont[ch] = 0.
    - On a split frame, SPLIT_CNT increments, saturating at 0xFFFF.
    - If the stored TLAST falls on exactly the limit word, the frame is not a split.
- Timing:
  - One idle cycle between frames (TLAST handshake → IDLE → HEADER).
  - Latency from the first input word of a complete 1-word packet to the output header is 3 cycles: write, IDLE grant, HEADER.
- Output stability: while TVALID & !TREADY, TDATA/TLAST/TVALID stay stable.
- TKEEP is always 8'hFF.

Test Plan:
- Ch0 sends a 3-word packet (D0..D2, TLAST on D2), MAC always ready → header 0xAA00_0000_0000_0000, then D0, D1, D2 with TLAST on D2; seq[0] becomes 1.
- Ch1 sends a 20-word packet, MAX_PAYLOAD_WORDS = 8 → three frames of 8, 8 and 4 payload words; cont bits in the headers are 0, 1, 1; SPLIT_CNT = 2.
- Channels 0..3 each hold one complete 2-word packet simultaneously → frames are emitted in order 0, 1, 2, 3. Ch0 then refills → ch0 is served after ch3.
- TX_M_AXIS_TREADY is toggled 1,0,0,1 during payload → no duplicated or lost words, and outputs stay stable while TREADY = 0.
- Ch2 is written with the MAC stalled until its FIFO fills with 16 words → S_AXIS_TREADY[2] = 0 while the other channels stay 1. Once the stall is released, frames drain and TREADY[2] returns to 1.
- TX_ARESETN is asserted mid-PAYLOAD → TVALID = 0 immediately, FIFOs empty, seq = 0. The next packet produces a header with seq 0.

Source files
------------

// File: rtl/ether_tx_mux.sv
// Multi-channel AXI-Stream to 10G MAC TX multiplexer: per-channel FIFOs, round-robin
// arbitration, one header word per frame and frame splitting at MAX_PAYLOAD_WORDS.
module ether_tx_mux #(
   parameter int CHANNEL_NUM       = 4,
   parameter int TDATA_WIDTH       = 64,
   parameter int FIFO_DEPTH        = 16,
   parameter int MAX_PAYLOAD_WORDS = 8
) (
   input  logic                               TX_ACLK,
   input  logic                               TX_ARESETN,
   input  logic [CHANNEL_NUM*TDATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic [CHANNEL_NUM-1:0]             S_AXIS_TVALID,
   input  logic [CHANNEL_NUM-1:0]             S_AXIS_TLAST,
   output logic [CHANNEL_NUM-1:0]             S_AXIS_TREADY,
   output logic [TDATA_WIDTH-1:0]             TX_M_AXIS_TDATA,
   output logic [7:0]                         TX_M_AXIS_TKEEP,
   output logic                               TX_M_AXIS_TVALID,
   output logic                               TX_M_AXIS_TLAST,
   output logic                               TX_M_AXIS_TUSER,
   input  logic                               TX_M_AXIS_TREADY,
   output logic [3:0]                         GRANT_CH,
   output logic [15:0]                        SPLIT_CNT
);

   localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = $clog2(MAX_PAYLOAD_WORDS + 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   ELIG_CNT = (AW + 1)'(MAX_PAYLOAD_WORDS);
   localparam logic [PW-1:0] LAST_IDX = PW'(MAX_PAYLOAD_WORDS - 1);

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

   state_t r_state, w_next;

   logic [TDATA_WIDTH:0]  r_mem  [CHANNEL_NUM][FIFO_DEPTH];
   logic [AW-1:0]         r_wptr [CHANNEL_NUM];
   logic [AW-1:0]         r_rptr [CHANNEL_NUM];
   logic [AW:0]           r_wcnt [CHANNEL_NUM];
   logic [AW:0]           r_pcnt [CHANNEL_NUM];
   logic [15:0]           r_seq  [CHANNEL_NUM];
   logic [CHANNEL_NUM-1:0] r_cont;
   logic                  r_rdy_en;
   logic [CW-1:0]         r_grant, r_ptr;
   logic [PW-1:0]         r_pay_cnt;
   logic [15:0]           r_split_cnt;

   logic [CHANNEL_NUM-1:0] w_rdy, w_wr, w_elig, w_pop_vec;
   logic [TDATA_WIDTH:0]   w_head;
   logic                   w_head_last, w_out_last, w_pop, w_frame_end, w_split;
   logic                   w_any;
   logic [CW-1:0]          w_sel;
   logic [63:0]            w_hdr;

   assign w_head      = r_mem[r_grant][r_rptr[r_grant]];
   assign w_head_last = w_head[TDATA_WIDTH];
   assign w_out_last  = w_head_last || (r_pay_cnt == LAST_IDX);
   assign w_pop       = (r_state == PAYLOAD) && TX_M_AXIS_TREADY;
   assign w_frame_end = w_pop && w_out_last;
   // A frame closed by the limit while the head word carries no TLAST is a split.
   assign w_split     = w_frame_end && !w_head_last;
   assign w_hdr       = {8'hAA, 4'h0, GRANT_CH, r_seq[r_grant], r_cont[r_grant], 31'h0};

   assign S_AXIS_TREADY   = w_rdy;
   assign TX_M_AXIS_TKEEP = 8'hFF;
   assign TX_M_AXIS_TUSER = 1'b0;
   assign GRANT_CH        = 4'(r_grant);
   assign SPLIT_CNT       = r_split_cnt;

   // NOTE: every signal written in always_comb gets a value before any branch, so no latch is inferred.
   always_comb begin
      w_rdy     = '0;
      w_wr      = '0;
      w_elig    = '0;
      w_pop_vec = '0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
         w_rdy[c]     = r_rdy_en && (r_wcnt[c] != FULL_CNT);
         w_wr[c]      = S_AXIS_TVALID[c] && w_rdy[c];
         w_elig[c]    = (r_pcnt[c] != '0) || (r_wcnt[c] >= ELIG_CNT);
         w_pop_vec[c] = w_pop && (r_grant == CW'(c));
      end
   end

   // Round-robin search starting just after the last served channel.
   always_comb begin
      logic [CW-1:0] w_cand;
      w_any  = 1'b0;
      w_sel  = '0;
      w_cand = '0;
      for (int i = 1; i <= CHANNEL_NUM; i++) begin
         w_cand = CW'((int'(r_ptr) + i) % CHANNEL_NUM);
         if (!w_any && w_elig[w_cand]) begin
            w_any = 1'b1;
            w_sel = w_cand;
         end
      end
   end

   // NOTE: FIFO storage has no reset; emptiness is defined by the pointers and counters alone.
   always_ff @(posedge TX_ACLK) begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
         if (w_wr[c]) begin
            r_mem[c][r_wptr[c]] <= {S_AXIS_TLAST[c], S_AXIS_TDATA[c*TDATA_WIDTH +: TDATA_WIDTH]};
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge TX_ACLK or negedge TX_ARESETN) begin
      if (!TX_ARESETN) begin
         r_rdy_en <= 1'b0;
         for (int c = 0; c < CHANNEL_NUM; c++) begin
            r_wptr[c] <= '0;
            r_rptr[c] <= '0;
            r_wcnt[c] <= '0;
            r_pcnt[c] <= '0;
         end
      end else begin
         r_rdy_en <= 1'b1;
         for (int c = 0; c < CHANNEL_NUM; c++) begin
            if (w_wr[c])      r_wptr[c] <= r_wptr[c] + 1'b1;
            if (w_pop_vec[c]) r_rptr[c] <= r_rptr[c] + 1'b1;
            case ({w_wr[c], w_pop_vec[c]})
               2'b10:   r_wcnt[c] <= r_wcnt[c] + 1'b1;
               2'b01:   r_wcnt[c] <= r_wcnt[c] - 1'b1;
               default: ;
            endcase
            case ({w_wr[c] && S_AXIS_TLAST[c], w_pop_vec[c] && w_head_last})
               2'b10:   r_pcnt[c] <= r_pcnt[c] + 1'b1;
               2'b01:   r_pcnt[c] <= r_pcnt[c] - 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge TX_ACLK or negedge TX_ARESETN) begin
      if (!TX_ARESETN) r_state <= IDLE;
      else             r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_any)            w_next = HEADER;
         HEADER:  if (TX_M_AXIS_TREADY) w_next = PAYLOAD;
         PAYLOAD: if (w_frame_end)      w_next = IDLE;
         default:                       w_next = IDLE;
      endcase
   end

   always_comb begin
      TX_M_AXIS_TVALID = 1'b0;
      TX_M_AXIS_TLAST  = 1'b0;
      TX_M_AXIS_TDATA  = '0;
      case (r_state)
         HEADER: begin
            TX_M_AXIS_TVALID = 1'b1;
            TX_M_AXIS_TDATA  = TDATA_WIDTH'(w_hdr);
         end
         PAYLOAD: begin
            TX_M_AXIS_TVALID = 1'b1;
            TX_M_AXIS_TDATA  = w_head[TDATA_WIDTH-1:0];
            TX_M_AXIS_TLAST  = w_out_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge TX_ACLK or negedge TX_ARESETN) begin
      if (!TX_ARESETN) begin
         r_grant     <= '0;
         r_ptr       <= CW'(CHANNEL_NUM - 1);
         r_pay_cnt   <= '0;
         r_cont      <= '0;
         r_split_cnt <= '0;
         for (int c = 0; c < CHANNEL_NUM; c++) r_seq[c] <= '0;
      end else begin
         if (r_state == IDLE && w_any) r_grant <= w_sel;
         if (r_state == HEADER)        r_pay_cnt <= '0;
         else if (w_pop)               r_pay_cnt <= r_pay_cnt + 1'b1;
         if (w_frame_end) begin
            r_ptr           <= r_grant;
            r_seq[r_grant]  <= r_seq[r_grant] + 16'd1;
            r_cont[r_grant] <= w_split;
            if (w_split && r_split_cnt != 16'hFFFF) r_split_cnt <= r_split_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ether_tx_mux.sv
// Directed and randomized bench for ether_tx_mux; a per-channel frame model predicts
// every output word, header field and the split count.
module tb_ether_tx_mux;

   localparam int NCH  = 4;
   localparam int W    = 64;
   localparam int MAXP = 8;

   logic             clk;
   logic             rst_n;
   logic [NCH*W-1:0] s_tdata;
   logic [NCH-1:0]   s_tvalid, s_tlast, s_tready;
   logic [W-1:0]     m_tdata;
   logic [7:0]       m_tkeep;
   logic             m_tvalid, m_tlast, m_tuser, m_tready;
   logic [3:0]       grant_ch;
   logic [15:0]      split_cnt;

   logic mac_rand, mac_fixed, rnd_rdy;
   assign m_tready = mac_rand ? rnd_rdy : mac_fixed;

   ether_tx_mux #(
      .CHANNEL_NUM(NCH), .TDATA_WIDTH(W), .FIFO_DEPTH(16), .MAX_PAYLOAD_WORDS(MAXP)
   ) dut (
      .TX_ACLK(clk),
      .TX_ARESETN(rst_n),
      .S_AXIS_TDATA(s_tdata),
      .S_AXIS_TVALID(s_tvalid),
      .S_AXIS_TLAST(s_tlast),
      .S_AXIS_TREADY(s_tready),
      .TX_M_AXIS_TDATA(m_tdata),
      .TX_M_AXIS_TKEEP(m_tkeep),
      .TX_M_AXIS_TVALID(m_tvalid),
      .TX_M_AXIS_TLAST(m_tlast),
      .TX_M_AXIS_TUSER(m_tuser),
      .TX_M_AXIS_TREADY(m_tready),
      .GRANT_CH(grant_ch),
      .SPLIT_CNT(split_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   // Reference model: words each channel has accepted, plus per-channel frame bookkeeping.
   logic [64:0] mq [NCH][$];
   logic [15:0] exp_seq  [NCH];
   bit          exp_cont [NCH];
   int          exp_split;
   bit          in_frame;
   int          cur_ch;
   int          pay_n;
   logic [63:0] hdr_log [$];
   int          grant_log [$];
   bit          prev_stall;
   logic [63:0] prev_data;
   logic        prev_last;

   int n_vec;
   int n_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin : mon
      int          hch;
      logic [64:0] w;
      bit          e_last;
      if (rst_n) begin
         if (prev_stall) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data", m_tdata, prev_data);
            chk("hold_last", m_tlast, prev_last);
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
         if (m_tvalid && m_tready) begin
            chk("tkeep", m_tkeep, 8'hFF);
            chk("tuser", m_tuser, 0);
            if (!in_frame) begin
               hch = int'(m_tdata[51:48]);
               chk("hdr_tag", m_tdata[63:52], 12'hAA0);
               chk("hdr_ch_range", hch < NCH, 1);
               if (hch >= NCH) hch = 0;
               chk("hdr_grant", grant_ch, hch);
               chk("hdr_seq", m_tdata[47:32], exp_seq[hch]);
               chk("hdr_cont", m_tdata[31], exp_cont[hch]);
               chk("hdr_zero", m_tdata[30:0], 0);
               chk("hdr_last", m_tlast, 0);
               hdr_log.push_back(m_tdata);
               grant_log.push_back(hch);
               in_frame = 1;
               cur_ch   = hch;
               pay_n    = 0;
            end else begin
               chk("pay_avail", mq[cur_ch].size() != 0, 1);
               if (mq[cur_ch].size() == 0) begin
                  in_frame = 0;
               end else begin
                  w      = mq[cur_ch].pop_front();
                  e_last = w[64] || (pay_n == MAXP - 1);
                  chk("pay_data", m_tdata, w[63:0]);
                  chk("pay_last", m_tlast, e_last);
                  pay_n++;
                  if (e_last) begin
                     in_frame          = 0;
                     exp_seq[cur_ch]   = exp_seq[cur_ch] + 16'd1;
                     exp_cont[cur_ch]  = !w[64];
                     if (!w[64] && exp_split < 65535) exp_split++;
                  end
               end
            end
         end
      end
   end

   task automatic put(input int ch, input logic [63:0] d, input logic last);
      bit ok = 0;
      s_tdata[ch*W +: W] = d;
      s_tlast[ch]        = last;
      s_tvalid[ch]       = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (s_tready[ch]) begin
            ok = 1;
            break;
         end
      end
      chk("put_accept", ok, 1);
      if (ok) mq[ch].push_back({last, d});
      @(posedge clk);
      #1;
      s_tvalid[ch] = 1'b0;
      s_tlast[ch]  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done = 0;
      int left;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         #1;
         left = 0;
         for (int c = 0; c < NCH; c++) left += mq[c].size();
         if (!in_frame && left == 0) begin
            done = 1;
            break;
         end
      end
      chk(tag, done, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   base;
      int   len;
      int   ch;
      bit   found;
      int   rr_exp [5];
      bit   pat [10];
      n_vec = 0;
      n_err = 0;
      s_tdata   = '0;
      s_tvalid  = '0;
      s_tlast   = '0;
      mac_rand  = 1'b0;
      mac_fixed = 1'b1;
      rst_n     = 1'b0;
      in_frame  = 0;
      prev_stall = 0;
      exp_split = 0;
      for (int c = 0; c < NCH; c++) begin
         exp_seq[c]  = '0;
         exp_cont[c] = 0;
      end

      // Reset values
      #3;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tkeep", m_tkeep, 8'hFF);
      chk("rst_tuser", m_tuser, 0);
      chk("rst_sready", s_tready, 0);
      chk("rst_grant", grant_ch, 0);
      chk("rst_split", split_cnt, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("ready_after_reset", s_tready, 4'hF);
      @(posedge clk);
      #1;

      // Ch0 3-word packet
      put(0, 64'h1000, 1'b0);
      put(0, 64'h1001, 1'b0);
      put(0, 64'h1002, 1'b1);
      wait_idle("t1_drain");
      chk("t1_frames", hdr_log.size(), 1);
      chk("t1_hdr", hdr_log[0], 64'hAA00_0000_0000_0000);

      // Latency of a 1-word packet: write, IDLE grant, HEADER
      put(3, 64'h3333, 1'b1);
      @(negedge clk);
      chk("lat_idle", m_tvalid, 0);
      @(negedge clk);
      chk("lat_hdr_valid", m_tvalid, 1);
      chk("lat_hdr_ch", m_tdata[51:48], 3);
      wait_idle("lat_drain");

      // Ch1 20-word packet splits into 8 + 8 + 4
      base = hdr_log.size();
      for (int i = 0; i < 20; i++) put(1, 64'h1_0000 + 64'(i), i == 19);
      wait_idle("t2_drain");
      chk("t2_frames", hdr_log.size() - base, 3);
      chk("t2_cont0", hdr_log[base][31], 0);
      chk("t2_cont1", hdr_log[base+1][31], 1);
      chk("t2_cont2", hdr_log[base+2][31], 1);
      chk("t2_split", split_cnt, 2);

      // Round robin over four loaded channels, ch0 refilled
      mac_fixed = 1'b0;
      base = grant_log.size();
      for (int c = 0; c < NCH; c++) begin
         put(c, 64'h2000 + 64'(c * 16), 1'b0);
         put(c, 64'h2001 + 64'(c * 16), 1'b1);
      end
      put(0, 64'h2100, 1'b0);
      put(0, 64'h2101, 1'b1);
      mac_fixed = 1'b1;
      wait_idle("t3_drain");
      rr_exp = '{0, 1, 2, 3, 0};
      chk("t3_frames", grant_log.size() - base, 5);
      for (int k = 0; k < 5; k++) chk("t3_order", grant_log[base+k], rr_exp[k]);
      chk("t3_ch0_seq", hdr_log[base][47:32], 1);

      // MAC ready toggling during payload
      mac_fixed = 1'b0;
      for (int i = 0; i < 4; i++) put(0, 64'h4000 + 64'(i), i == 3);
      found = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_tvalid) begin
            found = 1;
            break;
         end
      end
      chk("t4_hdr_seen", found, 1);
      pat = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 1};
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1 mac_fixed = pat[k];
      end
      mac_fixed = 1'b1;
      wait_idle("t4_drain");

      // Ch2 FIFO fills while the MAC is stalled
      mac_fixed = 1'b0;
      for (int i = 0; i < 16; i++) put(2, 64'h5000 + 64'(i), 1'b0);
      @(negedge clk);
      chk("t5_full", s_tready, 4'b1011);
      @(posedge clk);
      #1 mac_fixed = 1'b1;
      wait_idle("t5_drain");
      @(negedge clk);
      chk("t5_ready_back", s_tready, 4'hF);
      @(posedge clk);
      #1;

      // Reset in the middle of a payload
      for (int i = 0; i < 6; i++) put(1, 64'h6000 + 64'(i), i == 5);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (in_frame && pay_n >= 2) begin
            found = 1;
            break;
         end
      end
      chk("t6_mid_payload", found, 1);
      #2 rst_n = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         mq[c].delete();
         exp_seq[c]  = '0;
         exp_cont[c] = 0;
      end
      exp_split  = 0;
      in_frame   = 0;
      prev_stall = 0;
      #1;
      chk("t6_tvalid", m_tvalid, 0);
      chk("t6_tlast", m_tlast, 0);
      chk("t6_tdata", m_tdata, 0);
      chk("t6_tkeep", m_tkeep, 8'hFF);
      chk("t6_sready", s_tready, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t6_grant", grant_ch, 0);
      chk("t6_split", split_cnt, 0);
      chk("t6_sready_back", s_tready, 4'hF);

      // Ch0 and ch3 eligible in the same cycle after reset: ch0 wins
      base = grant_log.size();
      @(posedge clk);
      #1;
      s_tdata[0*W +: W] = 64'h7000;
      s_tdata[3*W +: W] = 64'h7003;
      s_tvalid = 4'b1001;
      s_tlast  = 4'b1001;
      @(negedge clk);
      chk("t6_par_ready", s_tready, 4'hF);
      mq[0].push_back({1'b1, 64'h7000});
      mq[3].push_back({1'b1, 64'h7003});
      @(posedge clk);
      #1;
      s_tvalid = '0;
      s_tlast  = '0;
      wait_idle("t6_drain");
      chk("t6_frames", grant_log.size() - base, 2);
      chk("t6_first", grant_log[base], 0);
      chk("t6_second", grant_log[base+1], 3);
      chk("t6_seq0", hdr_log[base][47:32], 0);
      chk("t6_seq3", hdr_log[base+1][47:32], 0);

      // Random packets with random MAC backpressure
      mac_rand = 1'b1;
      for (int p = 0; p < 40; p++) begin
         ch  = $urandom_range(0, NCH - 1);
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) put(ch, {$urandom, $urandom}, i == len - 1);
      end
      wait_idle("rand_drain");
      mac_rand = 1'b0;
      chk("rand_split", split_cnt, exp_split);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
